sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_ctrl_if.sv | 23 ++
 rtl/sram_ctrl_timer.sv | 16 +
 rtl/sram_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths, FSM states and wait-parameter limits for the SRAM controller
package sram_ctrl_pkg;
  localparam int SRAM_AW  = 20;
  localparam int SRAM_DW  = 16;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;
  function automatic bit wait_ok(int w);
    return w >= WAIT_MIN && w <= WAIT_MAX;
  endfunction
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: buffer-side handshake plus SRAM address/strobes; data buses stay plain inout ports
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;
  logic               i_read;
  logic               i_write;
  logic [31:0]        i_addr;
  logic               o_done;
  logic               o_err;
  logic [SRAM_AW-1:0] o_sram_addr;
  logic               o_sram_ce_n;
  logic               o_sram_oe_n;
  logic               o_sram_we_n;
  logic               o_sram_lb_n;
  logic               o_sram_ub_n;
  modport master (
    output i_read, i_write, i_addr,
    input  o_done, o_err, o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
  );
  modport slave (
    input  i_read, i_write, i_addr,
    output o_done, o_err, o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/sram_ctrl_timer.sv
// sram_ctrl_timer: wait counter cleared on state entry, flags the last cycle of a limit-long phase
module sram_ctrl_timer
  import sram_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign expired = cnt == limit - 1'b1;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM read/write sequencer with programmable strobe widths
// Optional SRAM_CTRL_RANGE_CHECK_EN: flag and skip requests whose address exceeds 20 bits.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_ctrl_if.slave         bus,
  inout  wire  [SRAM_DW-1:0] io_data,
  inout  wire  [SRAM_DW-1:0] io_sram_dq
);
  if (!wait_ok(RD_WAIT) || !wait_ok(WR_WAIT)) begin : g_bad_wait
    $error("sram_ctrl: RD_WAIT/WR_WAIT outside 1..15");
  end
  state_t             state, state_n;
  logic [SRAM_DW-1:0] wdata, rdata;
  logic               is_rd, acc, oor, expired, dq_oe, dat_oe;
  logic [CNT_W-1:0]   limit;
  assign acc   = state == S_IDLE && (bus.i_read ^ bus.i_write);
  assign limit = state == S_RD ? CNT_W'(RD_WAIT) : CNT_W'(WR_WAIT);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  logic err;
  assign oor = |bus.i_addr[31:SRAM_AW];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) err <= 1'b0;
    else if (acc) err <= oor;
  assign bus.o_err = state == S_DONE && err;
`else
  logic unused_hi;
  assign unused_hi = ^bus.i_addr[31:SRAM_AW];
  assign oor       = 1'b0;
  assign bus.o_err = 1'b0;
`endif
  sram_ctrl_timer u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (state_n != state),
    .limit  (limit),
    .expired(expired)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state           <= S_IDLE;
      bus.o_sram_addr <= '0;
      wdata           <= '0;
      rdata           <= '0;
      is_rd           <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        is_rd <= bus.i_read;
        if (!oor) bus.o_sram_addr <= bus.i_addr[SRAM_AW-1:0];
        if (bus.i_write) wdata <= io_data;
        if (oor) rdata <= '0;
      end
      if (state == S_RD && expired) rdata <= io_sram_dq;
    end
  // strobes decode straight from the async-reset state so reset deasserts them immediately
  always_comb begin
    state_n         = state;
    bus.o_done      = 1'b0;
    bus.o_sram_ce_n = 1'b1;
    bus.o_sram_oe_n = 1'b1;
    bus.o_sram_we_n = 1'b1;
    dq_oe           = 1'b0;
    dat_oe          = 1'b0;
    case (state)
      S_IDLE: state_n = !acc ? S_IDLE : oor ? S_DONE : bus.i_read ? S_RD : S_WR_SETUP;
      S_RD: begin
        bus.o_sram_ce_n = 1'b0;
        bus.o_sram_oe_n = 1'b0;
        state_n         = expired ? S_DONE : S_RD;
      end
      S_WR_SETUP: begin
        bus.o_sram_ce_n = 1'b0;
        dq_oe           = 1'b1;
        state_n         = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        bus.o_sram_ce_n = 1'b0;
        bus.o_sram_we_n = 1'b0;
        dq_oe           = 1'b1;
        state_n         = expired ? S_WR_HOLD : S_WR_PULSE;
      end
      S_WR_HOLD: begin
        bus.o_sram_ce_n = 1'b0;
        dq_oe           = 1'b1;
        state_n         = S_DONE;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        dat_oe     = is_rd;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    bus.o_sram_lb_n = bus.o_sram_ce_n;
    bus.o_sram_ub_n = bus.o_sram_ce_n;
  end
  assign io_sram_dq = dq_oe ? wdata : 'z;
  assign io_data    = dat_oe ? rdata : 'z;
endmodule
